dma_wr_sequencer: RTL and testbench
===================================

DMA_WR_SEQUENCER -- requirements
Module: dma_wr_sequencer

Interface
REQ-001 SHALL have parameter TLP_PAYLOAD_BYTES, default 128, max bytes per write request (power of two, 128..512).
REQ-002 SHALL have parameter NUM_BUFFERS, default 8, number of host buffers cycled.
REQ-003 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port control_reg  input  32  [0] DMA_ENABLE, [1] IRQ_ENABLE; other bits ignored.
REQ-006 SHALL have port dma_size  input  21  buffer size in bytes.
REQ-007 SHALL have port dma_host_addr  input  32  base address of buffer selected by status_reg[2:0].
REQ-008 SHALL have port fifo_count  input  11  data DWs available in acquisition FIFO.
REQ-009 SHALL have port tlp_req_valid / tlp_req_ready  output / input  1 / 1  write-request handshake.
REQ-010 SHALL have port tlp_req_addr  output  32  byte address of request.
REQ-011 SHALL have port tlp_req_len_dw  output  10  request payload length in DW.
REQ-012 SHALL have port tlp_done  input  1  one-cycle pulse: TX engine finished sending the accepted request.
REQ-013 SHALL have port irq_req / irq_ack  output / input  1 / 1  buffer-complete interrupt handshake.
REQ-014 SHALL have port status_reg  output  32  [2:0] curr_buff, [3] irq_pending, [4] busy, [5] size_error, [31:16] completed-buffer count.

Function
REQ-015 SHALL implement states IDLE, CHECK, REQ, WAIT_DONE, BUF_DONE.
REQ-016 IDLE -> CHECK when DMA_ENABLE=1; offset cleared to 0.
REQ-017 CHECK: if dma_size==0 or dma_size[1:0]!=0, set size_error, go IDLE; else compute len=min(dma_size-offset, TLP_PAYLOAD_BYTES) and go REQ once fifo_count >= len/4.
REQ-018 REQ: tlp_req_valid=1 with addr=dma_host_addr+offset, len_dw=len/4; addr/len held stable until tlp_req_ready=1 in the same cycle, then -> WAIT_DONE.
REQ-019 WAIT_DONE: on tlp_done, offset+=len; if offset==dma_size -> BUF_DONE else -> CHECK.
REQ-020 BUF_DONE (one cycle): curr_buff increments, wrapping NUM_BUFFERS-1 -> 0; completed count +1 (16-bit wrap); irq_pending set; offset cleared; -> CHECK if DMA_ENABLE else IDLE.
REQ-021 irq_req = irq_pending & IRQ_ENABLE; irq_pending clears the cycle after irq_ack=1; completion while pending is still pending (no queue), count still increments.
REQ-022 busy=1 in every state except IDLE.
REQ-023 DMA_ENABLE deassert: honoured only in IDLE, CHECK and BUF_DONE; an accepted request always runs to tlp_done.
REQ-024 size_error clears when DMA_ENABLE is rewritten 0->1.
REQ-025 Address arithmetic 32-bit modulo; offset 21-bit.

Reset
REQ-026 On rst_n=0: state IDLE, status_reg=0, tlp_req_valid=0, tlp_req_addr=0, tlp_req_len_dw=0, irq_req=0, offset=0.
REQ-027 Reset mid-transfer abandons the request immediately; no tlp_done tracking survives reset.

Configuration
REQ-028 Macro DMA_WR_4K_SPLIT_EN defined: len additionally limited to bytes up to next 4 KB boundary of tlp_req_addr (no request crosses 4 KB).
REQ-029 Macro undefined: no 4 KB limit; software SHALL place buffers 4 KB-aligned with TLP_PAYLOAD_BYTES-multiple sizes.

Structure
REQ-030 Shared package dma_pkg SHALL hold state encoding, control/status bit indices, TLP_PAYLOAD_BYTES default.
REQ-031 Sub-module dma_burst_calc SHALL compute len (min/4 KB logic) combinationally from addr, remaining, payload.

Verification
REQ-032 dma_size=512, payload 128, fifo_count=1023, ready always 1 -> 4 requests, addr base+0,+128,+256,+384, len_dw=32, then curr_buff=1, irq_req=1.
REQ-033 dma_size=200 -> requests len_dw 32 then 18; buffer completes after second tlp_done.
REQ-034 8 consecutive buffers -> curr_buff 7 wraps to 0, status_reg[31:16]=8.
REQ-035 dma_size=6 -> no request, status_reg[5]=1, busy=0; re-enable clears it.
REQ-036 DMA_WR_4K_SPLIT_EN, base 0x0000_0FC0, size 256 -> first request len_dw=16 (64 B to boundary), next at 0x1000.
REQ-037 tlp_req_ready held 0 for 10 cycles -> addr/len stable; DMA_ENABLE dropped during WAIT_DONE -> sequencer finishes request then returns IDLE.

Source files
------------

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared state encoding, register bit indices and defaults for the DMA write sequencer
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_REQ       = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_BUF_DONE  = 3'd4
    } dma_state_e;

    localparam int CTRL_DMA_EN    = 0;
    localparam int CTRL_IRQ_EN    = 1;

    localparam int STAT_BUFF_LSB  = 0;
    localparam int STAT_IRQ_PEND  = 3;
    localparam int STAT_BUSY      = 4;
    localparam int STAT_SIZE_ERR  = 5;
    localparam int STAT_COUNT_LSB = 16;

    localparam int DEFAULT_TLP_PAYLOAD_BYTES = 128;

    function automatic logic [20:0] min21(input logic [20:0] a, input logic [20:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/dma_burst_calc.sv
// rtl/dma_burst_calc.sv - byte length of the next write request
// DMA_WR_4K_SPLIT_EN additionally stops each request at the next 4 KB address boundary.
module dma_burst_calc
    import dma_pkg::*;
#(
    parameter int TLP_PAYLOAD_BYTES = DEFAULT_TLP_PAYLOAD_BYTES
) (
    input  logic [31:0] addr,
    input  logic [20:0] remaining,
    output logic [20:0] len_bytes
);

    localparam logic [20:0] PAYLOAD = 21'(TLP_PAYLOAD_BYTES);

`ifdef DMA_WR_4K_SPLIT_EN
    logic [20:0] to_4k;

    always_comb begin
        to_4k     = 21'd4096 - {9'd0, addr[11:0]};
        len_bytes = min21(min21(remaining, PAYLOAD), to_4k);
    end
`else
    logic unused_addr;

    assign unused_addr = ^addr;
    assign len_bytes   = min21(remaining, PAYLOAD);
`endif

endmodule

// File: rtl/dma_wr_sequencer.sv
// rtl/dma_wr_sequencer.sv - splits host buffers into write requests and cycles through NUM_BUFFERS buffers
// Optional DMA_WR_4K_SPLIT_EN (in dma_burst_calc) keeps every request inside one 4 KB page.
module dma_wr_sequencer
    import dma_pkg::*;
#(
    parameter int TLP_PAYLOAD_BYTES = DEFAULT_TLP_PAYLOAD_BYTES,
    parameter int NUM_BUFFERS       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] control_reg,
    input  logic [20:0] dma_size,
    input  logic [31:0] dma_host_addr,
    input  logic [10:0] fifo_count,
    output logic        tlp_req_valid,
    input  logic        tlp_req_ready,
    output logic [31:0] tlp_req_addr,
    output logic [9:0]  tlp_req_len_dw,
    input  logic        tlp_done,
    output logic        irq_req,
    input  logic        irq_ack,
    output logic [31:0] status_reg
);

    localparam logic [2:0] LAST_BUFF = 3'(NUM_BUFFERS - 1);

    dma_state_e  state_q, state_d;
    logic [20:0] offset_q, offset_d;
    logic [20:0] len_q, len_d;
    logic        req_valid_q, req_valid_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [9:0]  req_len_dw_q, req_len_dw_d;
    logic [2:0]  curr_buff_q, curr_buff_d;
    logic        irq_pending_q, irq_pending_d;
    logic        size_error_q, size_error_d;
    logic [15:0] buf_count_q, buf_count_d;
    logic        dma_en_prev_q, dma_en_prev_d;

    logic        dma_en, irq_en, dma_en_rise, size_bad;
    logic [31:0] cur_addr;
    logic [20:0] remaining, burst_len, next_offset;
    logic        unused_ctrl;

    assign dma_en      = control_reg[CTRL_DMA_EN];
    assign irq_en      = control_reg[CTRL_IRQ_EN];
    assign unused_ctrl = ^control_reg[31:2];
    assign dma_en_rise = dma_en & ~dma_en_prev_q;
    assign size_bad    = (dma_size == 21'd0) || (dma_size[1:0] != 2'b00);
    assign cur_addr    = dma_host_addr + {11'd0, offset_q};
    assign remaining   = dma_size - offset_q;
    assign next_offset = offset_q + len_q;

    dma_burst_calc #(
        .TLP_PAYLOAD_BYTES(TLP_PAYLOAD_BYTES)
    ) u_burst_calc (
        .addr      (cur_addr),
        .remaining (remaining),
        .len_bytes (burst_len)
    );

    always_comb begin
        state_d       = state_q;
        offset_d      = offset_q;
        len_d         = len_q;
        req_valid_d   = req_valid_q;
        req_addr_d    = req_addr_q;
        req_len_dw_d  = req_len_dw_q;
        curr_buff_d   = curr_buff_q;
        irq_pending_d = irq_pending_q;
        size_error_d  = size_error_q;
        buf_count_d   = buf_count_q;
        dma_en_prev_d = dma_en;

        if (dma_en_rise) size_error_d = 1'b0;
        if (irq_ack)     irq_pending_d = 1'b0;

        case (state_q)
            // A latched size error keeps the engine parked until software re-arms the enable bit.
            ST_IDLE: begin
                if (dma_en && (!size_error_q || dma_en_rise)) begin
                    state_d  = ST_CHECK;
                    offset_d = 21'd0;
                end
            end
            ST_CHECK: begin
                if (!dma_en) begin
                    state_d = ST_IDLE;
                end else if (size_bad) begin
                    size_error_d = 1'b1;
                    state_d      = ST_IDLE;
                end else if ({10'd0, fifo_count} >= (burst_len >> 2)) begin
                    state_d      = ST_REQ;
                    len_d        = burst_len;
                    req_valid_d  = 1'b1;
                    req_addr_d   = cur_addr;
                    req_len_dw_d = burst_len[11:2];
                end
            end
            ST_REQ: begin
                if (tlp_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = ST_WAIT_DONE;
                end
            end
            // Enable is deliberately ignored here: an accepted request must be tracked to completion.
            ST_WAIT_DONE: begin
                if (tlp_done) begin
                    offset_d = next_offset;
                    state_d  = (next_offset == dma_size) ? ST_BUF_DONE : ST_CHECK;
                end
            end
            ST_BUF_DONE: begin
                curr_buff_d   = (curr_buff_q == LAST_BUFF) ? 3'd0 : curr_buff_q + 3'd1;
                buf_count_d   = buf_count_q + 16'd1;
                irq_pending_d = 1'b1;
                offset_d      = 21'd0;
                state_d       = dma_en ? ST_CHECK : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            offset_q      <= 21'd0;
            len_q         <= 21'd0;
            req_valid_q   <= 1'b0;
            req_addr_q    <= 32'd0;
            req_len_dw_q  <= 10'd0;
            curr_buff_q   <= 3'd0;
            irq_pending_q <= 1'b0;
            size_error_q  <= 1'b0;
            buf_count_q   <= 16'd0;
            dma_en_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            offset_q      <= offset_d;
            len_q         <= len_d;
            req_valid_q   <= req_valid_d;
            req_addr_q    <= req_addr_d;
            req_len_dw_q  <= req_len_dw_d;
            curr_buff_q   <= curr_buff_d;
            irq_pending_q <= irq_pending_d;
            size_error_q  <= size_error_d;
            buf_count_q   <= buf_count_d;
            dma_en_prev_q <= dma_en_prev_d;
        end
    end

    assign tlp_req_valid  = req_valid_q;
    assign tlp_req_addr   = req_addr_q;
    assign tlp_req_len_dw = req_len_dw_q;
    assign irq_req        = irq_pending_q & irq_en;

    always_comb begin
        status_reg                           = 32'd0;
        status_reg[STAT_BUFF_LSB +: 3]       = curr_buff_q;
        status_reg[STAT_IRQ_PEND]            = irq_pending_q;
        status_reg[STAT_BUSY]                = (state_q != ST_IDLE);
        status_reg[STAT_SIZE_ERR]            = size_error_q;
        status_reg[STAT_COUNT_LSB +: 16]     = buf_count_q;
    end

endmodule

// File: tb/tb_dma_wr_sequencer.sv
// tb/tb_dma_wr_sequencer.sv - randomized self-checking bench for dma_wr_sequencer against a buffer-splitting model
module tb_dma_wr_sequencer;

    localparam int PAYLOAD = 128;
    localparam int NBUF    = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] control_reg;
    logic [20:0] dma_size;
    logic [31:0] dma_host_addr;
    logic [10:0] fifo_count;
    logic        tlp_req_valid, tlp_req_ready;
    logic [31:0] tlp_req_addr;
    logic [9:0]  tlp_req_len_dw;
    logic        tlp_done, irq_req, irq_ack;
    logic [31:0] status_reg;

    logic [31:0] base_tbl [NBUF];
    int          vectors = 0;
    int          miscompares = 0;
    int          exp_buff, exp_count;
    bit          exp_pending, rand_mode;
    logic [31:0] exp_addr_q [$];
    logic [9:0]  exp_len_q  [$];

    always #5 clk = ~clk;

    assign dma_host_addr = base_tbl[status_reg[2:0]];

    dma_wr_sequencer #(
        .TLP_PAYLOAD_BYTES(PAYLOAD),
        .NUM_BUFFERS      (NBUF)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .control_reg    (control_reg),
        .dma_size       (dma_size),
        .dma_host_addr  (dma_host_addr),
        .fifo_count     (fifo_count),
        .tlp_req_valid  (tlp_req_valid),
        .tlp_req_ready  (tlp_req_ready),
        .tlp_req_addr   (tlp_req_addr),
        .tlp_req_len_dw (tlp_req_len_dw),
        .tlp_done       (tlp_done),
        .irq_req        (irq_req),
        .irq_ack        (irq_ack),
        .status_reg     (status_reg)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected request list for one buffer: walk the buffer in payload-sized (and page-bounded) pieces.
    task automatic plan(input logic [31:0] base, input int size);
        int off;
        off = 0;
        exp_addr_q.delete();
        exp_len_q.delete();
        while (off < size) begin
            int          n;
            logic [31:0] a;
            a = base + off;
            n = size - off;
            if (n > PAYLOAD) n = PAYLOAD;
`ifdef DMA_WR_4K_SPLIT_EN
            if (n > 4096 - int'(a % 4096)) n = 4096 - int'(a % 4096);
`endif
            exp_addr_q.push_back(a);
            exp_len_q.push_back(10'(n / 4));
            off += n;
        end
    endtask

    task automatic run_buffer(input int size, input bit irq_en, input bit ack_after);
        int          nreq, guard, dly;
        bit          held;
        logic [31:0] h_addr, ea;
        logic [9:0]  h_len, el;
        plan(base_tbl[exp_buff], size);
        nreq        = exp_addr_q.size();
        dma_size    = 21'(size);
        control_reg = {30'h0, irq_en, 1'b1};
        held        = 0;
        guard       = 0;
        h_addr      = '0;
        h_len       = '0;
        while (nreq > 0 && guard < 5000) begin
            guard++;
            fifo_count    = rand_mode ? 11'($urandom_range(0, 1023)) : 11'd1023;
            tlp_req_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (held) begin
                chk("valid_held", tlp_req_valid, 1);
                chk("addr_stable", tlp_req_addr, h_addr);
                chk("len_stable", tlp_req_len_dw, h_len);
                held = 0;
            end
            if (tlp_req_valid && tlp_req_ready) begin
                ea = exp_addr_q.pop_front();
                el = exp_len_q.pop_front();
                chk("req_addr", tlp_req_addr, ea);
                chk("req_len_dw", tlp_req_len_dw, el);
                tick();
                tlp_req_ready = 1'b0;
                chk("valid_drop", tlp_req_valid, 0);
                dly = rand_mode ? $urandom_range(0, 3) : 0;
                repeat (dly) tick();
                tlp_done = 1'b1;
                nreq--;
                if (nreq == 0) control_reg = {30'h0, irq_en, 1'b0};
                tick();
                tlp_done = 1'b0;
            end else begin
                if (tlp_req_valid) begin
                    held   = 1;
                    h_addr = tlp_req_addr;
                    h_len  = tlp_req_len_dw;
                end
                tick();
            end
        end
        chk("all_reqs_issued", nreq, 0);
        tick();
        exp_buff    = (exp_buff + 1) % NBUF;
        exp_count   = (exp_count + 1) % 65536;
        exp_pending = 1;
        chk("curr_buff", status_reg[2:0], exp_buff);
        chk("buf_count", status_reg[31:16], exp_count);
        chk("irq_pending", status_reg[3], exp_pending);
        chk("irq_req", irq_req, exp_pending & irq_en);
        chk("idle_after_buf", status_reg[4], 0);
        if (ack_after) begin
            irq_ack = 1'b1;
            tick();
            irq_ack     = 1'b0;
            exp_pending = 0;
            chk("irq_cleared", status_reg[3], 0);
            chk("irq_req_low", irq_req, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          bad_seen;
        logic [31:0] h_addr;
        logic [9:0]  h_len;
        rst_n = 1'b0; control_reg = '0; dma_size = '0; fifo_count = '0;
        tlp_req_ready = 1'b0; tlp_done = 1'b0; irq_ack = 1'b0;
        for (int i = 0; i < NBUF; i++) base_tbl[i] = $urandom() & 32'hFFFF_F000;
        base_tbl[0] = 32'h1000_0000;
        exp_buff = 0; exp_count = 0; exp_pending = 0; rand_mode = 0;

        repeat (3) tick();
        chk("rst_status", status_reg, 0);
        chk("rst_valid", tlp_req_valid, 0);
        chk("rst_addr", tlp_req_addr, 0);
        chk("rst_len", tlp_req_len_dw, 0);
        chk("rst_irq", irq_req, 0);
        rst_n = 1'b1;
        tick();

        run_buffer(512, 1, 0);
        run_buffer(200, 1, 1);

        control_reg = '0;
        tick();
        dma_size = 21'd6; control_reg = 32'h1; bad_seen = 0;
        repeat (6) begin
            tick();
            if (tlp_req_valid) bad_seen = 1;
        end
        chk("size6_err", status_reg[5], 1);
        chk("size6_busy", status_reg[4], 0);
        chk("size6_noreq", bad_seen, 0);
        dma_size = 21'd0; control_reg = '0;
        tick();
        control_reg = 32'h1;
        repeat (4) tick();
        chk("size0_err", status_reg[5], 1);
        control_reg = '0;
        tick();
        run_buffer(64, 0, 0);
        chk("size_err_cleared", status_reg[5], 0);

        control_reg = '0;
        tick();
        dma_size = 21'd128; fifo_count = 11'd31; tlp_req_ready = 1'b0; control_reg = 32'h1;
        repeat (8) tick();
        chk("fifo_short_noreq", tlp_req_valid, 0);
        fifo_count = 11'd32;
        for (int i = 0; i < 4 && !tlp_req_valid; i++) tick();
        chk("fifo_ok_req", tlp_req_valid, 1);
        chk("hold_addr", tlp_req_addr, base_tbl[exp_buff]);
        chk("hold_len", tlp_req_len_dw, 32);
        h_addr = tlp_req_addr; h_len = tlp_req_len_dw; bad_seen = 0;
        repeat (10) begin
            tick();
            if (!tlp_req_valid || tlp_req_addr !== h_addr || tlp_req_len_dw !== h_len) bad_seen = 1;
        end
        chk("hold_stable", bad_seen, 0);
        tlp_req_ready = 1'b1;
        tick();
        tlp_req_ready = 1'b0;
        control_reg = '0;
        repeat (3) tick();
        chk("wait_done_busy", status_reg[4], 1);
        chk("wait_done_novalid", tlp_req_valid, 0);
        tlp_done = 1'b1;
        tick();
        tlp_done = 1'b0;
        tick();
        exp_buff = (exp_buff + 1) % NBUF; exp_count++; exp_pending = 1;
        chk("drop_en_idle", status_reg[4], 0);
        chk("drop_en_buff", status_reg[2:0], exp_buff);
        chk("drop_en_count", status_reg[31:16], exp_count);

`ifdef DMA_WR_4K_SPLIT_EN
        base_tbl[exp_buff] = 32'h0000_0FC0;
        run_buffer(256, 0, 1);
`endif

        rand_mode = 1;
        repeat (12) run_buffer($urandom_range(1, 400) * 4, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
